tis_port_reader: RTL

Read-side endpoint of the TIS-100 node-to-node port channel. It serves one node's read of UP, RIGHT, DOWN, LEFT, ANY, LAST or NIL. It blocks until a neighbour writer presents a word, acknowledges exactly one writer, and returns the word to the execution datapath (ALU operand mux / ACC load). It also maintains the LAST register used by later LAST reads.

---
 rtl/tis_port_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/tis_port_reader.sv
// TIS-100 port-channel read endpoint: blocks until a neighbour writer offers a
// word, acks exactly one writer, returns the word and tracks the LAST port.
module tis_port_reader #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rd_req,
   input  logic [2:0]     rd_src,
   input  logic [3:0]     in_valid,
   input  logic [4*N-1:0] in_data,
   output logic [3:0]     in_ack,
   output logic [N-1:0]   rd_data,
   output logic           rd_done,
   output logic           rd_busy,
   output logic [1:0]     last_port,
   output logic           last_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic [2:0]   src_q;
   logic [3:0]   cand;
   logic [3:0]   hit;
   logic [1:0]   gsel;
   logic         gnt_ok;
   logic [N-1:0] word;

   always_comb begin
      cand = '0;
      case (src_q)
         3'd0, 3'd1, 3'd2, 3'd3: cand[src_q[1:0]] = 1'b1;
         3'd4:                   cand = '1;
         3'd5:                   if (last_valid) cand[last_port] = 1'b1;
         default:                cand = '0;
      endcase

      hit    = cand & in_valid;
      gnt_ok = 1'b1;
      // fixed priority LEFT > RIGHT > UP > DOWN
      if (hit[3])      gsel = 2'd3;
      else if (hit[1]) gsel = 2'd1;
      else if (hit[0]) gsel = 2'd0;
      else if (hit[2]) gsel = 2'd2;
      else begin
         gsel   = 2'd0;
         gnt_ok = 1'b0;
      end

      word = in_data[gsel*N +: N];

      in_ack = '0;
      if (state == WAIT && gnt_ok) in_ack[gsel] = 1'b1;
   end

   assign rd_busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_q      <= '0;
         rd_data    <= '0;
         rd_done    <= 1'b0;
         last_port  <= '0;
         last_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               rd_done <= 1'b0;
               if (rd_req) begin
                  src_q <= rd_src;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cand == '0) begin
                  rd_data <= '0;
                  rd_done <= 1'b1;
                  state   <= DONE;
               end else if (gnt_ok) begin
                  rd_data <= word;
                  rd_done <= 1'b1;
                  state   <= DONE;
                  if (src_q == 3'd4) begin
                     last_port  <= gsel;
                     last_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               rd_done <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               rd_done <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
